piso32_tx: RTL and testbench
============================

PISO32_TX -- requirements
Module: piso32_tx

Interface
REQ-001 Parameter WIDTH, default 32; shift word width in bits, legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 1; 1 = transmit bit WIDTH-1 first, 0 = transmit bit 0 first.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-005 in_valid  input  1  parallel word offered.
REQ-006 in_data  input  WIDTH  parallel word to serialise.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 sout  output  1  serial data bit.
REQ-009 sout_valid  output  1  sout carries a frame bit this cycle.
REQ-010 sout_last  output  1  sout carries the final bit of the current word.
REQ-011 busy  output  1  a word is being shifted out.

Function
REQ-012 The block SHALL implement the states IDLE and SHIFT.
REQ-013 IDLE: in_ready=1, sout_valid=0, sout_last=0, busy=0, sout=0.
REQ-014 A handshake SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data is captured into the shift register, bit counter cleared to 0, state goes to SHIFT.
REQ-015 The first bit SHALL appear on sout with sout_valid=1 in the cycle immediately after the handshake (latency 1 cycle).
REQ-016 SHIFT: sout_valid=1, busy=1; sout = shift[WIDTH-1] when MSB_FIRST=1, shift[0] when MSB_FIRST=0; every rising edge the register shifts by one toward the output end and the counter increments.
REQ-017 A word SHALL occupy exactly WIDTH consecutive sout_valid cycles; sout_last=1 only when counter == WIDTH-1.
REQ-018 in_ready SHALL be 0 in SHIFT except in the sout_last cycle, where it is 1.
REQ-019 A handshake in the sout_last cycle SHALL load the new word and remain in SHIFT, so the new word's first bit follows the previous last bit with no gap.
REQ-020 Without a handshake in the sout_last cycle, state SHALL return to IDLE on that edge.
REQ-021 in_valid and in_data SHALL be ignored while in_ready=0; in_data changes during SHIFT SHALL NOT affect sout.
REQ-022 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.
REQ-023 Vacated shift-register positions SHALL fill with 0.

Reset
REQ-024 With reset=1 at a rising edge: state=IDLE, shift register=0, counter=0; after that edge in_ready=1 and sout, sout_valid, sout_last, busy=0.
REQ-025 reset SHALL take priority over a simultaneous handshake; the offered word is discarded.
REQ-026 reset asserted mid-word SHALL abort the word; no remaining bits of it are emitted.

Structure
REQ-027 Package piso_pkg SHALL hold the state enum type (IDLE, SHIFT) and the default WIDTH constant.
REQ-028 The shift register with load and direction control SHALL be the sub-module piso_shreg; the FSM, counter and handshake logic stay in piso32_tx.

Verification
REQ-029 Reset 2 cycles, then 0xA5A5A5A5 with MSB_FIRST=1 -> sout reads 1,0,1,0,0,1,0,1... over 32 sout_valid cycles; sout_last only on cycle 32; then IDLE.
REQ-030 Word 0x12345678, then in_valid held with 0xFFFFFFFF -> second handshake in the sout_last cycle; 64 contiguous sout_valid cycles; bits 33-64 all 1.
REQ-031 MSB_FIRST=0, word 0x00000001 -> first bit 1, remaining 31 bits 0.
REQ-032 in_valid=1 with in_data changed to 0xDEADBEEF during bit 5 of 0x0F0F0F0F -> output stays 0x0F0F0F0F pattern; in_ready=0 until the sout_last cycle.
REQ-033 reset=1 at bit 10 of 0xCAFEBABE -> next cycle sout_valid=0, busy=0, in_ready=1; a following word 0x80000000 starts cleanly with first bit 1.
REQ-034 Bench assertions: sout_last implies sout_valid; exactly WIDTH sout_valid cycles per accepted word; in_ready=0 whenever busy=1 and sout_last=0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the piso32_tx serialiser.
package piso_pkg;

  localparam int unsigned PISO_WIDTH_DEFAULT = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

endpackage

// File: rtl/piso32_tx_if.sv
// Parallel-in handshake plus serial-out signals of piso32_tx.
interface piso32_tx_if
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = PISO_WIDTH_DEFAULT
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, sout, sout_valid, sout_last, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, sout, sout_valid, sout_last, busy
  );

endinterface

// File: rtl/piso_shreg.sv
// Loadable shift register; shifts toward the output end, vacated bits fill with 0.
module piso_shreg
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = PISO_WIDTH_DEFAULT,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  always_comb begin
    shift_d = shift_q;
    if (load_i) begin
      shift_d = data_i;
    end else if (shift_i) begin
      shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign bit_o = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

endmodule

// File: rtl/piso32_tx.sv
// Parallel-to-serial transmitter: handshake FSM and bit counter around piso_shreg.
module piso32_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = PISO_WIDTH_DEFAULT,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  piso32_tx_if.slave  bus
);

  localparam int unsigned     CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  piso_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          ready_q;
  logic          valid_q;
  logic          last_q;
  logic          hs;
  logic          sh_bit;

  assign hs    = bus.in_valid & ready_q;
  assign cnt_d = cnt_q + 1'b1;

  // ready/last are registered one cycle ahead so the last-bit cycle can accept a word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        SHIFT: begin
          if (last_q) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
            if (hs) begin
              ready_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              ready_q <= 1'b1;
              valid_q <= 1'b0;
            end
          end else begin
            cnt_q   <= cnt_d;
            last_q  <= (cnt_d == LAST_CNT);
            ready_q <= (cnt_d == LAST_CNT);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (hs),
    .shift_i (valid_q & ~hs),
    .data_i  (bus.in_data),
    .bit_o   (sh_bit)
  );

  assign bus.in_ready   = ready_q;
  assign bus.sout_valid = valid_q;
  assign bus.sout_last  = last_q;
  assign bus.busy       = valid_q;
  assign bus.sout       = valid_q & sh_bit;

endmodule

// File: tb/tb_piso32_tx.sv
// Directed bench for piso32_tx: one MSB-first and one LSB-first instance.
module tb_piso32_tx;

  logic clk = 1'b0;
  logic reset;
  logic mon_en = 1'b0;
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned va = 0;
  int unsigned vb = 0;

  always #5 clk = ~clk;

  piso32_tx_if #(.WIDTH(32)) ifa ();
  piso32_tx_if #(.WIDTH(32)) ifb ();

  piso32_tx #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  piso32_tx #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {in_ready, sout_valid, sout_last, busy, sout}
  function automatic logic [4:0] outs(input bit sel);
    if (sel) return {ifb.in_ready, ifb.sout_valid, ifb.sout_last, ifb.busy, ifb.sout};
    return {ifa.in_ready, ifa.sout_valid, ifa.sout_last, ifa.busy, ifa.sout};
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [31:0] d);
    if (sel) begin ifb.in_valid = v; ifb.in_data = d; end
    else begin ifa.in_valid = v; ifa.in_data = d; end
  endtask

  task automatic set_valid(input bit sel, input logic v);
    if (sel) ifb.in_valid = v;
    else ifa.in_valid = v;
  endtask

  task automatic offer(input bit sel, input logic [31:0] w);
    int unsigned n;
    logic [4:0] o;
    @(negedge clk);
    n = 0;
    o = outs(sel);
    while (!o[4] && n < 16) begin
      @(negedge clk);
      o = outs(sel);
      n++;
    end
    chk("offer_ready", {63'd0, o[4]}, 64'd1);
    drive(sel, 1'b1, w);
  endtask

  // Checks the 32 frame cycles of w; at cycle chg_at applies nv/nd, at cycle 31 sets in_valid=last_v.
  task automatic expect_word(input bit sel, input logic [31:0] w, input string tag,
                             input logic nv, input logic [31:0] nd,
                             input int unsigned chg_at, input logic last_v);
    logic [4:0] e;
    logic b;
    for (int unsigned i = 0; i < 32; i++) begin
      @(negedge clk);
      b = sel ? w[i] : w[31-i];
      e = {(i == 31), 1'b1, (i == 31), 1'b1, b};
      chk($sformatf("%s[%0d]", tag, i), {59'd0, outs(sel)}, {59'd0, e});
      if (i == chg_at) drive(sel, nv, nd);
      if (i == 31) set_valid(sel, last_v);
    end
  endtask

  task automatic check_idle(input bit sel, input string tag);
    @(negedge clk);
    chk(tag, {59'd0, outs(sel)}, {59'd0, 5'b10000});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("A_last_imp_valid", {63'd0, ifa.sout_last & ~ifa.sout_valid}, 64'd0);
      chk("B_last_imp_valid", {63'd0, ifb.sout_last & ~ifb.sout_valid}, 64'd0);
      chk("A_ready_while_busy", {63'd0, ifa.busy & ~ifa.sout_last & ifa.in_ready}, 64'd0);
      chk("B_ready_while_busy", {63'd0, ifb.busy & ~ifb.sout_last & ifb.in_ready}, 64'd0);
      if (ifa.sout_valid === 1'b1) va++;
      if (ifb.sout_valid === 1'b1) vb++;
    end
  end

  initial begin
    logic [31:0] cb;
    cb = 32'hCAFEBABE;
    drive(1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_A", {59'd0, outs(1'b0)}, {59'd0, 5'b10000});
    chk("reset_B", {59'd0, outs(1'b1)}, {59'd0, 5'b10000});
    mon_en = 1'b1;
    reset = 1'b0;

    offer(1'b0, 32'hA5A5A5A5);
    expect_word(1'b0, 32'hA5A5A5A5, "a5", 1'b0, 32'd0, 0, 1'b0);
    check_idle(1'b0, "a5_idle");

    offer(1'b0, 32'h12345678);
    expect_word(1'b0, 32'h12345678, "b2b_w1", 1'b1, 32'hFFFFFFFF, 0, 1'b1);
    expect_word(1'b0, 32'hFFFFFFFF, "b2b_w2", 1'b0, 32'd0, 0, 1'b0);
    check_idle(1'b0, "b2b_idle");

    offer(1'b0, 32'h0F0F0F0F);
    expect_word(1'b0, 32'h0F0F0F0F, "ignore_din", 1'b1, 32'hDEADBEEF, 5, 1'b0);
    check_idle(1'b0, "ignore_idle");

    offer(1'b0, cb);
    for (int unsigned i = 0; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("abort_bit[%0d]", i), {59'd0, outs(1'b0)},
          {59'd0, 1'b0, 1'b1, 1'b0, 1'b1, cb[31-i]});
      if (i == 0) set_valid(1'b0, 1'b0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("abort_reset", {59'd0, outs(1'b0)}, {59'd0, 5'b10000});
    reset = 1'b0;
    offer(1'b0, 32'h80000000);
    expect_word(1'b0, 32'h80000000, "after_abort", 1'b0, 32'd0, 0, 1'b0);
    check_idle(1'b0, "after_abort_idle");

    @(negedge clk);
    drive(1'b0, 1'b1, 32'hFFFFFFFF);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_prio", {59'd0, outs(1'b0)}, {59'd0, 5'b10000});
    drive(1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_prio_discard", {59'd0, outs(1'b0)}, {59'd0, 5'b10000});

    offer(1'b1, 32'h00000001);
    expect_word(1'b1, 32'h00000001, "lsb_one", 1'b0, 32'd0, 0, 1'b0);
    check_idle(1'b1, "lsb_one_idle");
    offer(1'b1, 32'h12345678);
    expect_word(1'b1, 32'h12345678, "lsb_pat", 1'b0, 32'd0, 0, 1'b0);
    check_idle(1'b1, "lsb_pat_idle");

    // A: 32 + 64 + 32 + 11 (aborted) + 32 frame cycles; B: 2 words.
    chk("A_valid_total", {32'd0, va}, 64'd171);
    chk("B_valid_total", {32'd0, vb}, 64'd64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
